// File: rtl/uncached_dbus_sequencer.sv
// uncached_dbus_sequencer: serializes the two ports' uncached data requests onto a single-beat bus
module uncached_dbus_sequencer #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) (
  input  logic                             clk,
  input  logic                             resetn,
  input  logic [1:0]                       dreq_valid,
  input  logic [1:0][ADDR_WIDTH-1:0]       dreq_addr,
  input  logic [1:0][2:0]                  dreq_size,
  input  logic [1:0][DATA_WIDTH/8-1:0]     dreq_strobe,
  input  logic [1:0][DATA_WIDTH-1:0]       dreq_data,
  input  logic [1:0]                       d_uncache,
  output logic                             stall_out,
  output logic [1:0]                       dresp_data_ok,
  output logic [1:0][DATA_WIDTH-1:0]       dresp_data,
  output logic                             creq_valid,
  output logic                             creq_is_write,
  output logic [ADDR_WIDTH-1:0]            creq_addr,
  output logic [2:0]                       creq_size,
  output logic [DATA_WIDTH/8-1:0]          creq_strobe,
  output logic [DATA_WIDTH-1:0]            creq_data,
  input  logic                             cresp_ready,
  input  logic                             cresp_last,
  input  logic [DATA_WIDTH-1:0]            cresp_data
);
  typedef enum logic [1:0] {IDLE, REQ0, REQ1, DONE} state_e;
  state_e                         state_q, state_d;
  logic [1:0]                     mask_q, mask_d;
  logic [1:0][ADDR_WIDTH-1:0]     addr_q, addr_d;
  logic [1:0][2:0]                size_q, size_d;
  logic [1:0][DATA_WIDTH/8-1:0]   strobe_q, strobe_d;
  logic [1:0][DATA_WIDTH-1:0]     data_q, data_d;
  logic [1:0][DATA_WIDTH-1:0]     res_q, res_d;
  logic [1:0]                     active;
  logic                           sel, in_req, done;
  assign active = dreq_valid & d_uncache;
  assign sel    = state_q == REQ1;
  assign in_req = state_q == REQ0 || state_q == REQ1;
  assign done   = state_q == DONE;
  // state register and captured request/result registers
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q  <= IDLE;
      mask_q   <= '0;
      addr_q   <= '0;
      size_q   <= '0;
      strobe_q <= '0;
      data_q   <= '0;
      res_q    <= '0;
    end else begin
      state_q  <= state_d;
      mask_q   <= mask_d;
      addr_q   <= addr_d;
      size_q   <= size_d;
      strobe_q <= strobe_d;
      data_q   <= data_d;
      res_q    <= res_d;
    end
  end
  // capture in IDLE, walk active ports in order, one bus beat each, then report
  always_comb begin
    state_d  = state_q;
    mask_d   = mask_q;
    addr_d   = addr_q;
    size_d   = size_q;
    strobe_d = strobe_q;
    data_d   = data_q;
    res_d    = res_q;
    if (state_q == IDLE && |active) begin
      mask_d   = active;
      addr_d   = dreq_addr;
      size_d   = dreq_size;
      strobe_d = dreq_strobe;
      data_d   = dreq_data;
      state_d  = active[0] ? REQ0 : REQ1;
    end else if (in_req && cresp_ready && cresp_last) begin
      res_d[sel] = cresp_data;
      state_d    = (!sel && mask_q[1]) ? REQ1 : DONE;
    end else if (done) begin
      state_d = IDLE;
    end
  end
  // bus request and memory-stage response drive; stall is forced low while in reset
  always_comb begin
    stall_out     = resetn && (in_req || (state_q == IDLE && |active));
    creq_valid    = in_req;
    creq_is_write = in_req && |strobe_q[sel];
    creq_addr     = in_req ? addr_q[sel] : '0;
    creq_size     = in_req ? size_q[sel] : '0;
    creq_strobe   = in_req ? strobe_q[sel] : '0;
    creq_data     = in_req ? data_q[sel] : '0;
    dresp_data_ok = done ? mask_q : 2'b00;
    for (int i = 0; i < 2; i++) dresp_data[i] = (done && mask_q[i]) ? res_q[i] : '0;
  end
endmodule

// File: tb/tb_uncached_dbus_sequencer.sv
// tb_uncached_dbus_sequencer: randomized check of the uncached sequencer against a transaction-level model
module tb_uncached_dbus_sequencer;
  logic             clk = 0;
  logic             resetn = 0;
  logic [1:0]       dreq_valid = 0;
  logic [1:0][31:0] dreq_addr = 0;
  logic [1:0][2:0]  dreq_size = 0;
  logic [1:0][3:0]  dreq_strobe = 0;
  logic [1:0][31:0] dreq_data = 0;
  logic [1:0]       d_uncache = 0;
  logic             stall_out;
  logic [1:0]       dresp_data_ok;
  logic [1:0][31:0] dresp_data;
  logic             creq_valid, creq_is_write;
  logic [31:0]      creq_addr;
  logic [2:0]       creq_size;
  logic [3:0]       creq_strobe;
  logic [31:0]      creq_data;
  logic             cresp_ready = 0, cresp_last = 0;
  logic [31:0]      cresp_data = 0;
  int checks = 0, failures = 0;
  logic [1:0]  v, u;
  logic [31:0] a[2], dt[2], rdv[2];
  logic [2:0]  sz[2];
  logic [3:0]  st[2];
  int          dly[2];
  uncached_dbus_sequencer dut (
    .clk(clk), .resetn(resetn), .dreq_valid(dreq_valid), .dreq_addr(dreq_addr),
    .dreq_size(dreq_size), .dreq_strobe(dreq_strobe), .dreq_data(dreq_data),
    .d_uncache(d_uncache), .stall_out(stall_out), .dresp_data_ok(dresp_data_ok),
    .dresp_data(dresp_data), .creq_valid(creq_valid), .creq_is_write(creq_is_write),
    .creq_addr(creq_addr), .creq_size(creq_size), .creq_strobe(creq_strobe),
    .creq_data(creq_data), .cresp_ready(cresp_ready), .cresp_last(cresp_last),
    .cresp_data(cresp_data)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask
  task automatic gen();
    v = 2'($urandom);
    u = ($urandom_range(0, 4) == 0) ? 2'($urandom) : 2'b11;
    for (int k = 0; k < 2; k++) begin
      a[k]   = $urandom;
      dt[k]  = $urandom;
      rdv[k] = $urandom;
      sz[k]  = 3'($urandom_range(0, 2));
      st[k]  = $urandom_range(0, 1) ? 4'($urandom) : 4'h0;
      dly[k] = ($urandom_range(0, 9) == 0) ? 10 : $urandom_range(0, 3);
    end
  endtask
  task automatic drive();
    dreq_valid = v;
    d_uncache  = u;
    for (int k = 0; k < 2; k++) begin
      dreq_addr[k]   = a[k];
      dreq_size[k]   = sz[k];
      dreq_strobe[k] = st[k];
      dreq_data[k]   = dt[k];
    end
  endtask
  task automatic scramble();
    dreq_valid = 2'($urandom);
    d_uncache  = 2'($urandom);
    for (int k = 0; k < 2; k++) begin
      dreq_addr[k]   = $urandom;
      dreq_strobe[k] = 4'($urandom);
      dreq_data[k]   = $urandom;
      dreq_size[k]   = 3'($urandom);
    end
  endtask
  task automatic do_txn(input bit hold);
    logic [1:0] m;
    m = v & u;
    @(posedge clk); #1;
    drive(); #1;
    chk("idle_stall", stall_out, {31'b0, |m});
    chk("idle_cvalid", creq_valid, 0);
    chk("idle_ok", dresp_data_ok, 0);
    if (m == 0) return;
    @(posedge clk); #1;
    scramble();
    for (int k = 0; k < 2; k++) begin
      if (!m[k]) continue;
      for (int c = 0; c <= dly[k]; c++) begin
        cresp_ready = (c == dly[k]) || ((c < dly[k]) && $urandom_range(0, 3) == 0);
        cresp_last  = (c == dly[k]);
        cresp_data  = (c == dly[k]) ? rdv[k] : $urandom;
        #1;
        chk("req_valid", creq_valid, 1);
        chk("req_addr", creq_addr, a[k]);
        chk("req_size", creq_size, sz[k]);
        chk("req_strobe", creq_strobe, st[k]);
        chk("req_data", creq_data, dt[k]);
        chk("req_write", creq_is_write, {31'b0, st[k] != 0});
        chk("req_stall", stall_out, 1);
        chk("req_ok", dresp_data_ok, 0);
        @(posedge clk); #1;
      end
      cresp_ready = 0;
      cresp_last  = 0;
    end
    #1;
    chk("done_ok", dresp_data_ok, m);
    chk("done_d0", dresp_data[0], m[0] ? rdv[0] : 0);
    chk("done_d1", dresp_data[1], m[1] ? rdv[1] : 0);
    chk("done_stall", stall_out, 0);
    chk("done_cvalid", creq_valid, 0);
    if (hold) begin
      gen();
      v = 2'b11;
      u = 2'b11;
      drive(); #1;
      chk("done_hold_stall", stall_out, 0);
      chk("done_hold_cvalid", creq_valid, 0);
    end
  endtask
  initial begin
    bit h;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_stall", stall_out, 0);
    chk("rst_cvalid", creq_valid, 0);
    chk("rst_ok", dresp_data_ok, 0);
    @(negedge clk) resetn = 1;
    gen();
    v = 2'b01; u = 2'b01; a[0] = 32'h1FC0_0000; sz[0] = 2; st[0] = 0; rdv[0] = 32'hDEAD_BEEF; dly[0] = 2;
    do_txn(0);
    gen();
    v = 2'b11; u = 2'b11; a[0] = 32'h1FAF_0000; st[0] = 4'hF; dt[0] = 32'h1234_5678;
    a[1] = 32'h1FAF_0004; st[1] = 0; dly[0] = 1; dly[1] = 1;
    do_txn(0);
    gen();
    v = 2'b11; u = 2'b10;
    do_txn(0);
    gen();
    v = 2'b01; u = 2'b01; dly[0] = 10;
    do_txn(0);
    gen();
    v = 2'b11; u = 2'b11; a[1] = a[0];
    do_txn(0);
    gen();
    do_txn(1);
    do_txn(0);
    gen();
    v = 2'b11; u = 2'b11;
    @(posedge clk); #1;
    drive();
    @(posedge clk); #1;
    cresp_ready = 1; cresp_last = 1; cresp_data = $urandom;
    @(posedge clk); #1;
    cresp_ready = 0; cresp_last = 0; #1;
    chk("pre_rst_addr", creq_addr, a[1]);
    chk("pre_rst_valid", creq_valid, 1);
    resetn = 0; #1;
    chk("midrst_stall", stall_out, 0);
    chk("midrst_cvalid", creq_valid, 0);
    chk("midrst_addr", creq_addr, 0);
    chk("midrst_ok", dresp_data_ok, 0);
    @(posedge clk); #1;
    chk("midrst_cvalid2", creq_valid, 0);
    dreq_valid = 0;
    resetn = 1;
    gen();
    do_txn(0);
    gen();
    for (int i = 0; i < 150; i++) begin
      h = $urandom_range(0, 3) == 0;
      do_txn(h);
      if (!h) gen();
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
